// File: rtl/input_event_pkg.sv
// ----------------------------------------------------------------------------
// input_event_pkg
// Shared definitions for the board-input event controller: register-window
// byte offsets, register select decode, and pending-bit layout.
// ----------------------------------------------------------------------------
package input_event_pkg;

    localparam int NUM_BTN = 4;
    localparam int PEND_W  = 5;

    // Pending bit positions
    localparam int PEND_BTN0 = 0;
    localparam int PEND_BTN1 = 1;
    localparam int PEND_BTN2 = 2;
    localparam int PEND_BTN3 = 3;
    localparam int PEND_SW   = 4;

    // Byte offsets within the register window
    localparam logic [3:0] OFS_BTN  = 4'h0;
    localparam logic [3:0] OFS_SW   = 4'h4;
    localparam logic [3:0] OFS_PEND = 4'h8;
    localparam logic [3:0] OFS_MASK = 4'hC;

    // Word select derived from address bits [3:2]
    typedef enum logic [1:0] {
        SEL_BTN  = OFS_BTN[3:2],
        SEL_SW   = OFS_SW[3:2],
        SEL_PEND = OFS_PEND[3:2],
        SEL_MASK = OFS_MASK[3:2]
    } reg_sel_e;

    // Byte-offset bits [1:0] are don't-care; only the word index matters.
    function automatic reg_sel_e addr_to_sel(input logic [3:0] addr);
        return reg_sel_e'(addr[3:2]);
    endfunction

endpackage

// File: rtl/input_event_ctrl_if.sv
// ----------------------------------------------------------------------------
// input_event_ctrl_if
// LSU-side register window of the input event controller.
//   i_addr  [3:0]  byte offset, bits [3:2] select the register
//   i_rd_en        read strobe
//   i_wr_en        write strobe
//   i_wdata [31:0] write data
//   o_rdata [31:0] registered read data
//   o_irq          maskable interrupt, |(pending & mask)
// master: the LSU side; slave: the controller.
// ----------------------------------------------------------------------------
interface input_event_ctrl_if;

    logic [3:0]  i_addr;
    logic        i_rd_en;
    logic        i_wr_en;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_irq;

    modport master (
        output i_addr, i_rd_en, i_wr_en, i_wdata,
        input  o_rdata, o_irq
    );

    modport slave (
        input  i_addr, i_rd_en, i_wr_en, i_wdata,
        output o_rdata, o_irq
    );

endinterface

// File: rtl/debounce_cell.sv
// ----------------------------------------------------------------------------
// debounce_cell
// One push-button bit: two-flop synchronizer followed by a stability counter.
// A change on the synchronized input is accepted only after it has held for
// DB_LIMIT consecutive cycles.
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_raw     asynchronous raw button, 1 = pressed
//   o_stable  debounced level
//   o_rise    one-cycle strobe, high in the cycle whose edge takes o_stable 0->1
// ----------------------------------------------------------------------------
module debounce_cell #(
    parameter int DB_LIMIT = 50000,
    parameter int DB_CNT_W = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_LIMIT - 1);

    logic                s1;
    logic                s2;
    logic [DB_CNT_W-1:0] cnt;
    logic                differs;
    logic                accept;

    assign differs = (s2 != o_stable);
    // The counter never passes CNT_LAST: reaching it while still differing
    // commits the new level and clears the count, so it cannot wrap.
    assign accept  = differs && (cnt == CNT_LAST);
    assign o_rise  = accept && s2;

    // NOTE: every flop here uses <= so s1 -> s2 -> stable shift as a true
    // pipeline; a blocking assignment would collapse the synchronizer stages.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            o_stable <= 1'b0;
            cnt      <= '0;
        end else begin
            s1 <= i_raw;
            s2 <= s1;
            if (accept) begin
                o_stable <= s2;
                cnt      <= '0;
            end else if (differs) begin
                cnt <= cnt + DB_CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/input_event_ctrl.sv
// ----------------------------------------------------------------------------
// input_event_ctrl
// Synchronizes and debounces the board buttons, synchronizes the switches,
// latches button-press and switch-change events into sticky pending bits and
// raises a maskable interrupt. The LSU reads state and clears events through
// a four-word register window.
//   i_clk     system clock
//   i_rst     synchronous active-high reset
//   i_io_btn  raw buttons [3:0], asynchronous, 1 = pressed
//   i_io_sw   raw switches [31:0], asynchronous
//   bus       register window (slave side): addr/rd/wr/wdata in, rdata/irq out
// Registers: 0x0 BTN (RO), 0x4 SW (RO), 0x8 PEND (W1C), 0xC MASK (RW, [4:0])
// ----------------------------------------------------------------------------
module input_event_ctrl
    import input_event_pkg::*;
#(
    parameter int DB_LIMIT = 50000,
    parameter int DB_CNT_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_BTN-1:0] i_io_btn,
    input  logic [31:0]        i_io_sw,
    input_event_ctrl_if.slave  bus
);

    logic [NUM_BTN-1:0] btn_stable;
    logic [NUM_BTN-1:0] btn_rise;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_cell #(
            .DB_LIMIT (DB_LIMIT),
            .DB_CNT_W (DB_CNT_W)
        ) u_db (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .i_raw    (i_io_btn[g]),
            .o_stable (btn_stable[g]),
            .o_rise   (btn_rise[g])
        );
    end

    // Switches need no debounce; s2 is their stable value. sw_prev trails
    // sw_s2 by one cycle for change detection and resets to 0 alongside it,
    // so reset itself never looks like a change.
    logic [31:0] sw_s1;
    logic [31:0] sw_s2;
    logic [31:0] sw_prev;
    logic        sw_change;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sw_s1   <= '0;
            sw_s2   <= '0;
            sw_prev <= '0;
        end else begin
            sw_s1   <= i_io_sw;
            sw_s2   <= sw_s1;
            sw_prev <= sw_s2;
        end
    end

    assign sw_change = (sw_s2 != sw_prev);

    reg_sel_e           sel;
    logic [PEND_W-1:0]  pend;
    logic [PEND_W-1:0]  mask;
    logic [PEND_W-1:0]  pend_set;
    logic [PEND_W-1:0]  pend_clr;
    logic [PEND_W-1:0]  pend_next;
    logic [31:0]        rd_mux;

    assign sel = addr_to_sel(bus.i_addr);

    // NOTE: each always_comb output is given a default before any condition,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pend_set                     = '0;
        pend_set[PEND_BTN3:PEND_BTN0] = btn_rise;
        pend_set[PEND_SW]            = sw_change;

        pend_clr = '0;
        if (bus.i_wr_en && (sel == SEL_PEND)) begin
            pend_clr = bus.i_wdata[PEND_W-1:0];
        end

        // Clear first, then OR in new events: a set coinciding with its
        // W1C clear leaves the bit at 1 so the event is not lost.
        pend_next = (pend & ~pend_clr) | pend_set;
    end

    // Read mux sees pre-write register values, so a PEND read in the same
    // cycle as a PEND write returns the value before the clear.
    always_comb begin
        rd_mux = '0;
        case (sel)
            SEL_BTN:  rd_mux = 32'(btn_stable);
            SEL_SW:   rd_mux = sw_s2;
            SEL_PEND: rd_mux = 32'(pend);
            SEL_MASK: rd_mux = 32'(mask);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend        <= '0;
            mask        <= '0;
            bus.o_rdata <= '0;
        end else begin
            pend <= pend_next;
            if (bus.i_wr_en && (sel == SEL_MASK)) begin
                mask <= bus.i_wdata[PEND_W-1:0];
            end
            if (bus.i_rd_en) begin
                bus.o_rdata <= rd_mux;
            end
        end
    end

    assign bus.o_irq = |(pend & mask);

    // Byte-lane address bits and upper write-data bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{bus.i_addr[1:0], bus.i_wdata[31:PEND_W]};

endmodule

// File: tb/tb_input_event_ctrl.sv
// ----------------------------------------------------------------------------
// tb_input_event_ctrl
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a history-based reference model: a button level is accepted once
// the last DB_LIMIT synchronized samples all disagree with the current level;
// a switch event fires when consecutive synchronized samples differ.
// ----------------------------------------------------------------------------
module tb_input_event_ctrl;
    import input_event_pkg::*;

    localparam int L    = 4;
    localparam int HIST = 8192;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  btn;
    logic [31:0] sw;

    input_event_ctrl_if bus ();

    input_event_ctrl #(
        .DB_LIMIT (L),
        .DB_CNT_W (16)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_io_btn (btn),
        .i_io_sw  (sw),
        .bus      (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [3:0]  btn_hist [HIST];
    logic [31:0] sw_hist  [HIST];
    int          e_cnt    = 0;
    int          last_rst = -100;
    logic [3:0]  m_stable = '0;
    logic [4:0]  m_pend   = '0;
    logic [4:0]  m_mask   = '0;
    logic [31:0] m_rdata  = '0;

    // Raw value sampled at edge i, as later seen by the DUT; samples taken
    // at or before the latest reset were flushed by it and read as 0.
    function automatic logic [3:0] btn_at(input int i);
        if (i < 0 || i <= last_rst) return 4'b0;
        return btn_hist[i];
    endfunction

    function automatic logic [31:0] sw_at(input int i);
        if (i < 0 || i <= last_rst) return 32'b0;
        return sw_hist[i];
    endfunction

    task automatic model_edge();
        int          e;
        logic [31:0] sw_now;
        logic [31:0] sw_old;
        logic [3:0]  rise;
        logic [4:0]  clr;
        logic        flip;
        e = e_cnt;
        btn_hist[e] = btn;
        sw_hist[e]  = sw;
        if (rst) begin
            last_rst = e;
            m_stable = '0;
            m_pend   = '0;
            m_mask   = '0;
            m_rdata  = '0;
        end else begin
            // value visible to the DUT at this edge is two samples old
            sw_now = sw_at(e - 2);
            sw_old = sw_at(e - 3);
            if (bus.i_rd_en) begin
                case (bus.i_addr[3:2])
                    2'd0: m_rdata = {28'b0, m_stable};
                    2'd1: m_rdata = sw_now;
                    2'd2: m_rdata = {27'b0, m_pend};
                    default: m_rdata = {27'b0, m_mask};
                endcase
            end
            rise = '0;
            for (int b = 0; b < 4; b++) begin
                flip = 1'b1;
                for (int i = e - 1 - L; i <= e - 2; i++) begin
                    if (btn_at(i)[b] == m_stable[b]) flip = 1'b0;
                end
                if (flip) begin
                    if (!m_stable[b]) rise[b] = 1'b1;
                    m_stable[b] = ~m_stable[b];
                end
            end
            clr = '0;
            if (bus.i_wr_en && bus.i_addr[3:2] == 2'd2) clr = bus.i_wdata[4:0];
            m_pend = (m_pend & ~clr) | {sw_now != sw_old, rise};
            if (bus.i_wr_en && bus.i_addr[3:2] == 2'd3) m_mask = bus.i_wdata[4:0];
        end
        e_cnt++;
    endtask

    // ---------------- checking / stepping ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check({tag, ".rdata"}, bus.o_rdata, m_rdata);
        check({tag, ".irq"}, 32'(bus.o_irq), 32'(|(m_pend & m_mask)));
    endtask

    task automatic bus_idle();
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;
        bus.i_addr  = 4'h0;
        bus.i_wdata = 32'h0;
    endtask

    task automatic set_rd(input logic [3:0] a);
        bus.i_rd_en = 1'b1;
        bus.i_wr_en = 1'b0;
        bus.i_addr  = a;
    endtask

    task automatic set_wr(input logic [3:0] a, input logic [31:0] d);
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b1;
        bus.i_addr  = a;
        bus.i_wdata = d;
    endtask

    initial begin
        // 1. Reset with btn0 held, then one event DB_LIMIT+1 edges after release
        rst = 1'b1;
        btn = 4'b0001;
        sw  = 32'h0;
        bus_idle();
        tick("t1_rst");
        tick("t1_rst");
        check("t1_rst_rdata", bus.o_rdata, 32'h0);
        check("t1_rst_irq", 32'(bus.o_irq), 32'h0);
        rst = 1'b0;
        repeat (4) tick("t1_hold");             // edges k..k+3
        set_rd(OFS_PEND);
        tick("t1_hold");                        // k+4
        tick("t1_hold");                        // k+5: set happens here
        check("t1_pend_pre", bus.o_rdata, 32'h0);
        tick("t1_hold");                        // k+6
        check("t1_pend_set", bus.o_rdata, 32'h1);
        set_rd(OFS_BTN);
        tick("t1_btn");
        check("t1_btn", bus.o_rdata, 32'h1);
        set_wr(OFS_PEND, 32'h1F);
        tick("t1_clr");
        bus_idle();
        repeat (6) tick("t1_held");
        set_rd(OFS_PEND);
        tick("t1_single");
        check("t1_single", bus.o_rdata, 32'h0);
        btn = 4'b0000;
        bus_idle();
        repeat (8) tick("t1_rel");
        set_rd(OFS_PEND);
        tick("t1_rel_pend");
        check("t1_release_no_event", bus.o_rdata, 32'h0);
        set_rd(OFS_BTN);
        tick("t1_rel_btn");
        check("t1_release_btn", bus.o_rdata, 32'h0);

        // 2. Bounce on btn1, then hold
        bus_idle();
        btn = 4'b0010; tick("t2_bounce");
        btn = 4'b0000; tick("t2_bounce");
        btn = 4'b0010; tick("t2_bounce");
        btn = 4'b0000; tick("t2_bounce");
        btn = 4'b0010;                          // hold begins at edge h
        set_rd(OFS_BTN);
        repeat (5) tick("t2_hold");             // h..h+4
        tick("t2_hold");                        // h+5: stable updates here
        check("t2_btn_before", bus.o_rdata, 32'h0);
        tick("t2_hold");                        // h+6
        check("t2_btn_after", bus.o_rdata, 32'h2);
        set_rd(OFS_PEND);
        tick("t2_pend");
        check("t2_pend_single", bus.o_rdata, 32'h2);
        set_wr(OFS_PEND, 32'h1F);
        btn = 4'b0000;
        tick("t2_clr");
        bus_idle();
        repeat (8) tick("t2_rel");

        // 3. Glitch shorter than DB_LIMIT on btn2
        btn = 4'b0100;
        repeat (3) tick("t3_glitch");
        btn = 4'b0000;
        set_rd(OFS_BTN);
        for (int i = 0; i < 10; i++) begin
            tick("t3_watch");
            check("t3_btn", bus.o_rdata, 32'h0);
        end
        set_rd(OFS_PEND);
        tick("t3_pend");
        check("t3_pend", bus.o_rdata, 32'h0);

        // 4. Switch event and irq
        set_wr(OFS_MASK, 32'h10);
        tick("t4_mask");
        bus_idle();
        sw = 32'hA5A5_0000;
        tick("t4_sw");                          // edge k
        tick("t4_sw");                          // k+1
        check("t4_irq_pre", 32'(bus.o_irq), 32'h0);
        set_rd(OFS_SW);
        tick("t4_sw");                          // k+2
        check("t4_irq", 32'(bus.o_irq), 32'h1);
        check("t4_sw_read", bus.o_rdata, 32'hA5A5_0000);
        set_rd(OFS_PEND);
        tick("t4_pend");
        check("t4_pend", bus.o_rdata, 32'h10);
        set_wr(OFS_PEND, 32'h10);
        tick("t4_clr");
        check("t4_irq_clr", 32'(bus.o_irq), 32'h0);
        bus_idle();

        // 5. W1C clear in the same cycle as a btn3 rise
        btn = 4'b1000;
        repeat (5) tick("t5_hold");             // k..k+4
        set_wr(OFS_PEND, 32'h1F);
        tick("t5_race");                        // k+5: set and clear coincide
        set_rd(OFS_PEND);
        tick("t5_pend");
        check("t5_pend", bus.o_rdata, 32'h08);
        check("t5_irq_masked", 32'(bus.o_irq), 32'h0);
        set_wr(OFS_MASK, 32'h08);
        tick("t5_mask");
        check("t5_irq_unmasked", 32'(bus.o_irq), 32'h1);
        set_wr(OFS_PEND, 32'h08);
        tick("t5_clr");
        check("t5_irq_clr", 32'(bus.o_irq), 32'h0);

        // 6. Masking of pending[0]
        set_wr(OFS_MASK, 32'h1E);
        tick("t6_mask");
        bus_idle();
        btn = 4'b1001;
        repeat (6) tick("t6_hold");             // pending[0] set at 6th edge
        set_rd(OFS_PEND);
        tick("t6_pend");
        check("t6_pend", bus.o_rdata, 32'h01);
        check("t6_irq_masked", 32'(bus.o_irq), 32'h0);
        set_wr(OFS_MASK, 32'h1F);
        tick("t6_unmask");
        check("t6_irq", 32'(bus.o_irq), 32'h1);
        set_wr(OFS_PEND, 32'h1F);
        tick("t6_clr");
        bus_idle();

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 4) == 0) btn[b] = ~btn[b];
            end
            if ($urandom_range(0, 7) == 0) sw = $urandom;
            bus.i_rd_en = ($urandom_range(0, 1) == 1);
            bus.i_wr_en = ($urandom_range(0, 3) == 0);
            bus.i_addr  = 4'($urandom);
            bus.i_wdata = $urandom;
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/input_event_ctrl.md
# input_event_ctrl

Controller that sits between the raw board inputs (4 push-buttons, 32 slide switches) and the LSU read path. It synchronizes every input, debounces the buttons, captures button-press and switch-change events into sticky pending bits, and raises a maskable interrupt. The LSU reads debounced state and event status, and clears events, through a small word-addressed register window.

## Interface

Parameters:
- DB_LIMIT, 16'd50000, consecutive stable cycles required before a button change is accepted (≥2)
- DB_CNT_W, 16, width of each debounce counter; DB_LIMIT must fit

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset, synchronous, active-high
- i_io_btn  input  4  raw buttons, asynchronous, 1 = pressed
- i_io_sw  input  32  raw switches, asynchronous
- i_addr  input  4  byte offset within window; bits [3:2] select register
- i_rd_en  input  1  read strobe
- i_wr_en  input  1  write strobe
- i_wdata  input  32  write data
- o_rdata  output  32  read data, registered
- o_irq  output  1  |(pending & mask)

## Operation

- Sync: every input bit passes through 2 flops (s1, s2). Switches use s2 directly as their stable value.
- Button debounce, per bit:
  - cnt increments each cycle s2 != stable.
  - cnt returns to 0 on any cycle s2 == stable.
  - When cnt == DB_LIMIT-1 and s2 still differs, stable <= s2 and cnt <= 0.
- Events:
  - pending[3:0]: set on a debounced button rising edge (stable 0->1). Release sets nothing.
  - pending[4]: set when the switch s2 vector differs from its previous-cycle value.
  - pending[31:5] read as 0.
- Register map:
  - 0x0 BTN: {28'b0, btn_stable}, RO
  - 0x4 SW: sw_s2, RO
  - 0x8 PEND: write-1-to-clear
  - 0xC MASK: RW, bits [4:0] only, upper bits read 0
- Writes to RO offsets are ignored.
- Simultaneous set and W1C clear of the same pending bit: set wins, bit stays 1.
- Simultaneous i_rd_en and i_wr_en to PEND: read returns the pre-write value.
- o_rdata holds its last value when i_rd_en = 0.
- Reset mid-debounce discards partial counts. No spurious event after reset, even if buttons are held: stable and the previous-switch register reset to 0, then a held button produces one event after DB_LIMIT.

## Timing

- Reset values are all 0: s1, s2, stable, cnt, prev_sw, pending, mask, o_rdata, o_irq.
- Raw button change sampled at edge k:
  - s2 valid after edge k+1.
  - stable and pending update at edge k+1+DB_LIMIT, if the input holds throughout.
- Raw switch change sampled at edge k sets pending[4] at edge k+2.
- Read latency is 1: address and i_rd_en presented in cycle n, o_rdata valid after edge n+1.
- Writes take effect at the edge where i_wr_en is sampled.
- o_irq is combinational from the pending and mask flops. It asserts in the cycle after the pending set edge, or immediately after a MASK write, and deasserts after the clearing write.
- Counters saturate by construction and never wrap. A glitch shorter than DB_LIMIT cycles never changes stable.

## Structure

- Package input_event_pkg:
  - register offsets OFS_BTN, OFS_SW, OFS_PEND, OFS_MASK
  - pending bit indices PEND_BTN0..3, PEND_SW
  - PEND_W = 5
- Sub-module debounce_cell: one bit, parameterized by DB_LIMIT and DB_CNT_W, containing the sync pair, counter and stable flop. It outputs stable and rise. Instantiate it 4x for the buttons.
- The top level holds the switch sync, change detect, pending/mask registers, read mux and irq.

## Test plan

Bench uses DB_LIMIT = 4.

1. Reset: assert i_rst 2 cycles with buttons held -> all outputs 0. After release, btn0 held produces one pending[0] event at cycle 5 after the first sample.
2. Bounce: btn1 toggles 1,0,1,0 on consecutive cycles, then holds 1 -> BTN reads 0x2 exactly 5 edges after the hold begins, with a single pending[1] set.
3. Glitch: btn2 high for 3 cycles -> BTN stays 0x0 and PEND stays 0x0.
4. Switch event and irq: write MASK = 0x10; i_io_sw goes 0x0 to 0xA5A5_0000 -> pending[4] at edge k+2 and o_irq = 1. Read SW returns 0xA5A5_0000 one cycle after the strobe.
5. W1C race: a PEND write of 0x1F in the same cycle btn3 rises -> PEND reads 0x08 and o_irq follows MASK.
6. Masking: pending = 0x01 with MASK = 0x1E -> o_irq = 0. Writing MASK = 0x1F -> o_irq = 1 the next cycle.
